// File: rtl/arrow_pkg.sv
// Shared types and grid geometry for the arrow-key cursor scheduler.
package arrow_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam int GRID_DIM   = 6;
  localparam int GRID_CELLS = GRID_DIM * GRID_DIM;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_HOLD   = 2'd2,
    WAIT_REPEAT = 2'd3
  } state_t;

endpackage

// File: rtl/key_edge_detect.sv
// Two-flop synchronizer per key plus a rising-edge pulse on the synchronized level.
module key_edge_detect (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keys,
  output logic [3:0] level,
  output logic [3:0] rise
);

  logic [3:0] sync_p0;
  logic [3:0] sync_p1;
  logic [3:0] prev_p2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      sync_p0 <= keys;
      // p0 -> p1: metastability settling stage
      sync_p1 <= sync_p0;
      // p1 -> p2: previous synchronized level for edge detection
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~prev_p2;

endmodule

// File: rtl/arrow_move_scheduler.sv
// Arbitrates arrow-key presses into cursor moves on a 6x6 grid, with hold-to-repeat.
module arrow_move_scheduler
  import arrow_pkg::*;
#(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keys,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [5:0] pos,
  output logic [5:0] next_pos
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [5:0] DIM = 6'(GRID_DIM);

  function automatic logic is_blocked(input logic [5:0] p, input dir_t d);
    logic [5:0] row;
    logic [5:0] col;
    row = p / DIM;
    col = p - row * DIM;
    case (d)
      UP:      is_blocked = (row == 6'd0);
      DOWN:    is_blocked = (row == DIM - 6'd1);
      LEFT:    is_blocked = (col == 6'd0);
      default: is_blocked = (col == DIM - 6'd1);
    endcase
  endfunction

  function automatic logic [5:0] step(input logic [5:0] p, input dir_t d);
    case (d)
      UP:      step = p - DIM;
      DOWN:    step = p + DIM;
      LEFT:    step = p - 6'd1;
      default: step = p + 6'd1;
    endcase
  endfunction

  // Lowest offset after the last grant wins; the last grant itself comes last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  logic [3:0] key_lvl;
  logic [3:0] key_rise;

  key_edge_detect u_key_edge_detect (
    .clock (clock),
    .reset (reset),
    .keys  (keys),
    .level (key_lvl),
    .rise  (key_rise)
  );

  state_t           state_q, state_d;
  logic [3:0]       pending_q;
  logic [3:0]       auto_q;
  logic [1:0]       rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_lim;
  logic [5:0]       pos_q;
  logic [5:0]       nxt_q;
  logic [1:0]       dir_q;
  logic             issue_auto_q, issue_auto_d;
  logic [1:0]       grant;
  logic [3:0]       grant_clr;
  logic [3:0]       rep_set;
  logic             load_move;
  logic             accept;

  assign cnt_lim = (state_q == WAIT_HOLD) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(REPEAT_CYCLES - 1);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    issue_auto_d = issue_auto_q;
    grant        = rr_pick(pending_q, rr_q);
    grant_clr    = '0;
    rep_set      = '0;
    load_move    = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_clr[grant] = 1'b1;
          rr_d             = grant;
          // A blocked move is consumed here and never presented.
          if (!is_blocked(pos_q, dir_t'(grant))) begin
            state_d      = ISSUE;
            load_move    = 1'b1;
            issue_auto_d = auto_q[grant];
          end
        end
      end
      ISSUE: begin
        if (move_ready) begin
          accept  = 1'b1;
          state_d = issue_auto_q ? WAIT_REPEAT : WAIT_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        if (!key_lvl[dir_q] || (|pending_q)) begin
          state_d = IDLE;
        end else if (cnt_q == cnt_lim) begin
          rep_set[dir_q] = 1'b1;
          state_d        = WAIT_REPEAT;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      auto_q       <= '0;
      rr_q         <= 2'd3;
      cnt_q        <= '0;
      issue_auto_q <= 1'b0;
      pos_q        <= '0;
      nxt_q        <= '0;
      dir_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
      issue_auto_q <= issue_auto_d;
      pending_q    <= (pending_q & ~grant_clr) | key_rise | rep_set;
      // Auto flag marks a pending bit raised by the repeat timer rather than a fresh press.
      auto_q       <= (auto_q & ~grant_clr & ~key_rise) | rep_set;
      if (load_move) begin
        dir_q <= grant;
        nxt_q <= step(pos_q, dir_t'(grant));
      end
      if (accept) pos_q <= nxt_q;
    end
  end

  assign move_valid = (state_q == ISSUE);
  assign move_dir   = dir_q;
  assign pos        = pos_q;
  assign next_pos   = nxt_q;

endmodule

// File: tb/tb_arrow_move_scheduler.sv
// Directed bench for arrow_move_scheduler with short hold/repeat timing.
module tb_arrow_move_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] keys;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [5:0] pos;
  logic [5:0] next_pos;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int vcycles = 0;
  int acc_n = 0;
  logic [1:0] acc_dir [64];
  logic [5:0] acc_pos [64];
  int         acc_cyc [64];

  arrow_move_scheduler #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .keys       (keys),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .pos        (pos),
    .next_pos   (next_pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Handshake log: a move seen valid&ready here is taken on the following rising edge.
  always @(negedge clock) begin
    #1;
    if (move_valid === 1'b1) vcycles = vcycles + 1;
    if (move_valid === 1'b1 && move_ready === 1'b1 && reset === 1'b0 && acc_n < 64) begin
      acc_dir[acc_n] = move_dir;
      acc_pos[acc_n] = next_pos;
      acc_cyc[acc_n] = cyc;
      acc_n = acc_n + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    keys = 4'b0;
    move_ready = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clock);
    keys = k;
    tick(2);
    keys = 4'b0;
    tick(10);
  endtask

  task automatic test_reset();
    apply_reset();
    tick(1);
    nvec++; if (move_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %0b want 0", move_valid); end
    nvec++; if (pos !== 6'd0) begin nerr++; $display("FAIL rst_pos: got %0d want 0", pos); end
    nvec++; if (next_pos !== 6'd0) begin nerr++; $display("FAIL rst_next_pos: got %0d want 0", next_pos); end
    nvec++; if (move_dir !== 2'd0) begin nerr++; $display("FAIL rst_dir: got %0d want 0", move_dir); end
  endtask

  task automatic test_single_right();
    int base;
    base = acc_n;
    @(negedge clock);
    keys = 4'b1000;
    tick(2);
    keys = 4'b0;
    tick(1);
    nvec++; if (move_valid !== 1'b0) begin nerr++; $display("FAIL lat_early: got %0b want 0", move_valid); end
    tick(1);
    nvec++; if (move_valid !== 1'b1) begin nerr++; $display("FAIL lat_valid: got %0b want 1", move_valid); end
    nvec++; if (move_dir !== 2'd3) begin nerr++; $display("FAIL lat_dir: got %0d want 3", move_dir); end
    nvec++; if (next_pos !== 6'd1) begin nerr++; $display("FAIL lat_next: got %0d want 1", next_pos); end
    tick(1);
    nvec++; if (pos !== 6'd1) begin nerr++; $display("FAIL single_pos: got %0d want 1", pos); end
    nvec++; if (move_valid !== 1'b0) begin nerr++; $display("FAIL single_drop: got %0b want 0", move_valid); end
    tick(8);
    nvec++; if (acc_n - base !== 1) begin nerr++; $display("FAIL single_count: got %0d want 1", acc_n - base); end
  endtask

  task automatic test_blocked();
    int base;
    int v0;
    apply_reset();
    base = acc_n;
    v0 = vcycles;
    press(4'b0001);
    press(4'b0100);
    nvec++; if (vcycles - v0 !== 0) begin nerr++; $display("FAIL blocked_valid: got %0d want 0", vcycles - v0); end
    nvec++; if (pos !== 6'd0) begin nerr++; $display("FAIL blocked_pos: got %0d want 0", pos); end
    press(4'b0010);
    nvec++; if (pos !== 6'd6) begin nerr++; $display("FAIL blocked_down: got %0d want 6", pos); end
    nvec++; if (acc_n - base !== 1) begin nerr++; $display("FAIL blocked_count: got %0d want 1", acc_n - base); end
  endtask

  task automatic test_round_robin();
    int base;
    press(4'b0010);
    press(4'b1000);
    press(4'b1000);
    nvec++; if (pos !== 6'd14) begin nerr++; $display("FAIL rr_setup: got %0d want 14", pos); end
    base = acc_n;
    press(4'b0101);
    tick(5);
    nvec++; if (acc_n - base !== 2) begin nerr++; $display("FAIL rr_count: got %0d want 2", acc_n - base); end
    nvec++; if (acc_dir[base] !== 2'd0) begin nerr++; $display("FAIL rr_dir0: got %0d want 0", acc_dir[base]); end
    nvec++; if (acc_pos[base] !== 6'd8) begin nerr++; $display("FAIL rr_pos0: got %0d want 8", acc_pos[base]); end
    nvec++; if (acc_dir[base+1] !== 2'd2) begin nerr++; $display("FAIL rr_dir1: got %0d want 2", acc_dir[base+1]); end
    nvec++; if (acc_pos[base+1] !== 6'd7) begin nerr++; $display("FAIL rr_pos1: got %0d want 7", acc_pos[base+1]); end
    nvec++; if (pos !== 6'd7) begin nerr++; $display("FAIL rr_final: got %0d want 7", pos); end
  endtask

  task automatic test_backpressure();
    int budget;
    @(negedge clock);
    move_ready = 1'b0;
    keys = 4'b1000;
    tick(2);
    keys = 4'b0;
    budget = 10;
    while (move_valid !== 1'b1 && budget > 0) begin
      tick(1);
      budget--;
    end
    nvec++; if (move_valid !== 1'b1) begin nerr++; $display("FAIL bp_wait: got valid %0b want 1 within 10 cycles", move_valid); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      nvec++; if (move_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid: cycle %0d got %0b want 1", i, move_valid); end
      nvec++; if (move_dir !== 2'd3) begin nerr++; $display("FAIL bp_dir: cycle %0d got %0d want 3", i, move_dir); end
      nvec++; if (next_pos !== 6'd8) begin nerr++; $display("FAIL bp_next: cycle %0d got %0d want 8", i, next_pos); end
      nvec++; if (pos !== 6'd7) begin nerr++; $display("FAIL bp_pos: cycle %0d got %0d want 7", i, pos); end
    end
    move_ready = 1'b1;
    tick(1);
    nvec++; if (pos !== 6'd8) begin nerr++; $display("FAIL bp_accept: got %0d want 8", pos); end
    nvec++; if (move_valid !== 1'b0) begin nerr++; $display("FAIL bp_done: got %0b want 0", move_valid); end
    tick(8);
  endtask

  task automatic test_auto_repeat();
    int base;
    int c0;
    int exp_off [5];
    exp_off = '{4, 15, 22, 29, 36};
    apply_reset();
    base = acc_n;
    @(negedge clock);
    keys = 4'b1000;
    c0 = cyc;
    tick(50);
    keys = 4'b0;
    tick(10);
    nvec++; if (acc_n - base !== 5) begin nerr++; $display("FAIL rep_count: got %0d want 5", acc_n - base); end
    for (int i = 0; i < 5; i++) begin
      nvec++; if (acc_cyc[base+i] - c0 !== exp_off[i]) begin nerr++; $display("FAIL rep_time: move %0d got %0d want %0d", i, acc_cyc[base+i] - c0, exp_off[i]); end
      nvec++; if (acc_pos[base+i] !== 6'(i + 1)) begin nerr++; $display("FAIL rep_pos: move %0d got %0d want %0d", i, acc_pos[base+i], i + 1); end
    end
    nvec++; if (pos !== 6'd5) begin nerr++; $display("FAIL rep_sat: got %0d want 5", pos); end
  endtask

  task automatic test_reset_in_issue();
    int budget;
    int v0;
    press(4'b0100);
    press(4'b0100);
    press(4'b0100);
    press(4'b0010);
    press(4'b0010);
    press(4'b0010);
    nvec++; if (pos !== 6'd20) begin nerr++; $display("FAIL rii_setup: got %0d want 20", pos); end
    @(negedge clock);
    move_ready = 1'b0;
    keys = 4'b0010;
    tick(2);
    keys = 4'b0;
    budget = 10;
    while (move_valid !== 1'b1 && budget > 0) begin
      tick(1);
      budget--;
    end
    nvec++; if (move_valid !== 1'b1) begin nerr++; $display("FAIL rii_wait: got valid %0b want 1 within 10 cycles", move_valid); end
    reset = 1'b1;
    tick(1);
    nvec++; if (move_valid !== 1'b0) begin nerr++; $display("FAIL rii_valid: got %0b want 0", move_valid); end
    nvec++; if (pos !== 6'd0) begin nerr++; $display("FAIL rii_pos: got %0d want 0", pos); end
    nvec++; if (next_pos !== 6'd0) begin nerr++; $display("FAIL rii_next: got %0d want 0", next_pos); end
    reset = 1'b0;
    move_ready = 1'b1;
    v0 = vcycles;
    tick(10);
    nvec++; if (vcycles - v0 !== 0) begin nerr++; $display("FAIL rii_quiet: got %0d valid cycles want 0", vcycles - v0); end
  endtask

  task automatic test_hold_through_reset();
    int base;
    base = acc_n;
    @(negedge clock);
    reset = 1'b1;
    keys = 4'b1000;
    tick(3);
    reset = 1'b0;
    tick(8);
    keys = 4'b0;
    tick(10);
    nvec++; if (acc_n - base !== 1) begin nerr++; $display("FAIL htr_count: got %0d want 1", acc_n - base); end
    nvec++; if (pos !== 6'd1) begin nerr++; $display("FAIL htr_pos: got %0d want 1", pos); end
  endtask

  initial begin
    reset = 1'b1;
    keys = 4'b0;
    move_ready = 1'b1;
    test_reset();
    test_single_right();
    test_blocked();
    test_round_robin();
    test_backpressure();
    test_auto_repeat();
    test_reset_in_issue();
    test_hold_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
